// File: rtl/bcd_accumulator.sv
// bcd_accumulator: digit-serial packed-BCD accumulator feeding the 7-segment
// display stage. One operand digit is added per clock, least significant first;
// the visible total changes only on a completed operation, clear or Reset.
// Optional feature macro: BCD_ACC_SUBTRACT_EN adds the op_sub port and
// ten's-complement subtraction (borrow reported on carry_out).
module bcd_accumulator #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   operand,
`ifdef BCD_ACC_SUBTRACT_EN
  input  logic                  op_sub,
`endif
  output logic [4*DIGITS-1:0]   acc_bcd,
  output logic                  carry_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADD,
    DONE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    opnd_q;
  logic [W-1:0]    work_q;
  logic            c_q;
`ifdef BCD_ACC_SUBTRACT_EN
  logic            sub_q;
`endif

  logic [3:0]      acc_dig;
  logic [3:0]      op_dig;
  logic [3:0]      b_dig;
  logic [4:0]      s;
  logic [4:0]      s_adj;
  logic            c_next;
  logic [3:0]      dig;
  logic [W-1:0]    work_next;
  logic            bad_digit;
  logic            final_carry;

  // Single-digit BCD add of the digit selected by idx, plus operand validity check
  always_comb begin
    acc_dig   = '0;
    op_dig    = '0;
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        acc_dig = acc_bcd[4*i +: 4];
        op_dig  = opnd_q[4*i +: 4];
      end
      if (opnd_q[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
`ifdef BCD_ACC_SUBTRACT_EN
    b_dig = sub_q ? (4'd9 - op_dig) : op_dig;
`else
    b_dig = op_dig;
`endif
    s      = {1'b0, acc_dig} + {1'b0, b_dig} + {4'b0000, c_q};
    s_adj  = s + 5'd6;
    c_next = (s > 5'd9);
    dig    = c_next ? s_adj[3:0] : s[3:0];
    work_next = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        work_next[4*i +: 4] = dig;
      end
    end
`ifdef BCD_ACC_SUBTRACT_EN
    // a ten's-complement subtract borrows exactly when no final carry emerges
    final_carry = sub_q ? ~c_next : c_next;
`else
    final_carry = c_next;
`endif
  end

  // Control FSM with registered outputs; partial sums live in work_q until DONE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= '0;
      opnd_q    <= '0;
      work_q    <= '0;
      c_q       <= 1'b0;
`ifdef BCD_ACC_SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
      acc_bcd   <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (clear) begin
            acc_bcd   <= '0;
            carry_out <= 1'b0;
          end else if (start) begin
            opnd_q <= operand;
`ifdef BCD_ACC_SUBTRACT_EN
            sub_q  <= op_sub;
`endif
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (bad_digit) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
`ifdef BCD_ACC_SUBTRACT_EN
            c_q <= sub_q;
`else
            c_q <= 1'b0;
`endif
            idx    <= '0;
            work_q <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          work_q <= work_next;
          c_q    <= c_next;
          // the last digit's result is committed straight from work_next so
          // that acc_bcd and done rise on the same edge
          if (idx == LAST_IDX) begin
            acc_bcd   <= work_next;
            carry_out <= final_carry;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_accumulator.sv
// tb_bcd_accumulator: directed test of bcd_accumulator with DIGITS=2.
// Subtraction steps are built only when BCD_ACC_SUBTRACT_EN is defined.
module tb_bcd_accumulator;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W = 4 * DIGITS;

  logic         Clock;
  logic         Reset;
  logic         start;
  logic         clear;
  logic [W-1:0] operand;
  logic         op_sub;
  logic [W-1:0] acc_bcd;
  logic         carry_out;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks;
  int n_fail;

  bcd_accumulator #(.DIGITS(DIGITS)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .clear     (clear),
    .operand   (operand),
`ifdef BCD_ACC_SUBTRACT_EN
    .op_sub    (op_sub),
`endif
    .acc_bcd   (acc_bcd),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, result and the return to idle.
  // Latency is counted in edges after the edge that samples start.
  task automatic op_check(input string tag, input logic [W-1:0] opv, input logic sub,
                          input int exp_lat, input logic [W-1:0] exp_acc,
                          input logic exp_co, input logic exp_err);
    int lat;
    operand = opv;
    op_sub  = sub;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clock); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_acc"}, 32'(acc_bcd), 32'(exp_acc));
    chk({tag, "_carry"}, 32'(carry_out), 32'(exp_co));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(posedge Clock); #1;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    operand  = '0;
    op_sub   = 1'b0;

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_acc", 32'(acc_bcd), 32'h00);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // adds: 00+47=47, 47+58=105 -> 05 carry
    op_check("add47", 8'h47, 1'b0, 3, 8'h47, 1'b0, 1'b0);
    op_check("add58", 8'h58, 1'b0, 3, 8'h05, 1'b1, 1'b0);

    // invalid digit: err with done after CHECK, total and carry untouched
    op_check("bad3A", 8'h3A, 1'b0, 1, 8'h05, 1'b1, 1'b1);

    // start pulsed again while busy: one done only, second operand ignored
    operand = 8'h12;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    operand = 8'h33;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      @(posedge Clock); #1;
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_acc", 32'(acc_bcd), 32'h17);
    chk("busy_start_carry", 32'(carry_out), 32'd0);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // clear and start together in IDLE: clear wins, no operation starts
    operand = 8'h21;
    clear   = 1'b1;
    start   = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    start = 1'b0;
    chk("clrstart_acc", 32'(acc_bcd), 32'h00);
    chk("clrstart_busy", 32'(busy), 32'd0);
    @(posedge Clock); #1;
    chk("clrstart_busy2", 32'(busy), 32'd0);
    chk("clrstart_done", 32'(done), 32'd0);

    // wrap modulo 100
    op_check("add99", 8'h99, 1'b0, 3, 8'h99, 1'b0, 1'b0);
    op_check("add01", 8'h01, 1'b0, 3, 8'h00, 1'b1, 1'b0);

    // reset during ADD aborts with everything cleared
    operand = 8'h25;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("midrst_acc", 32'(acc_bcd), 32'h00);
    chk("midrst_carry", 32'(carry_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    ndone = 0;
    repeat (6) begin
      @(posedge Clock); #1;
      if (done) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);
    chk("midrst_acc_hold", 32'(acc_bcd), 32'h00);

    // clear while busy is ignored
    operand = 8'h11;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    clear = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    ndone = 0;
    repeat (8) begin
      if (done) ndone++;
      @(posedge Clock); #1;
    end
    chk("busy_clear_ndone", 32'(ndone), 32'd1);
    chk("busy_clear_acc", 32'(acc_bcd), 32'h11);

`ifdef BCD_ACC_SUBTRACT_EN
    // subtract: 05-07 = 98 with borrow, 98-08 = 90 no borrow
    clear = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    chk("sub_clear_acc", 32'(acc_bcd), 32'h00);
    op_check("sub_pre05", 8'h05, 1'b0, 3, 8'h05, 1'b0, 1'b0);
    op_check("sub07", 8'h07, 1'b1, 3, 8'h98, 1'b1, 1'b0);
    op_check("sub08", 8'h08, 1'b1, 3, 8'h90, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
